// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: measures line/frame timing of an asynchronous hsync/vsync pair
// and reports lock once two consecutive frames agree.
`default_nettype none

module vga_sync_monitor #(
   parameter bit HPOL = 1'b1,
   parameter bit VPOL = 1'b1
) (
   input  logic        clk,
   input  logic        RSTn,
   input  logic        hsync,
   input  logic        vsync,
   output logic [10:0] htotal,
   output logic [10:0] hpulse,
   output logic [10:0] vtotal,
   output logic [10:0] vpulse,
   output logic [10:0] hcnt_rx,
   output logic [10:0] vcnt_rx,
   output logic        locked,
   output logic        frame_done,
   output logic        err
);

   localparam logic [1:0]  ST_SEARCH  = 2'd0;
   localparam logic [1:0]  ST_MEASURE = 2'd1;
   localparam logic [1:0]  ST_LOCKED  = 2'd2;
   localparam logic [10:0] CNT_MAX    = 11'd2047;
   localparam logic [10:0] CNT_PRE    = 11'd2046;

   logic [1:0]  hsync_q, vsync_q;
   logic        hact_q, vact_q;
   logic [10:0] lc_q, lc_d, vc_q, vc_d, vp_q, vp_d;
   logic [10:0] htotal_q, htotal_d, hpulse_q, hpulse_d;
   logic [10:0] vtotal_q, vtotal_d, vpulse_q, vpulse_d;
   logic [10:0] cand_h_q, cand_h_d, cand_v_q, cand_v_d;
   logic [1:0]  state_q, state_d;
   logic        hseen_q, hseen_d, arm_q, arm_d;
   logic        fd_q, fd_d, err_q, err_d;

   logic h_act, v_act, h_lead, h_trail, v_lead, v_trail;
   logic h_upd, measure, timeout;

   assign h_act   = HPOL ? hsync_q[1] : ~hsync_q[1];
   assign v_act   = VPOL ? vsync_q[1] : ~vsync_q[1];
   assign h_lead  =  h_act & ~hact_q;
   assign h_trail = ~h_act &  hact_q;
   assign v_lead  =  v_act & ~vact_q;
   assign v_trail = ~v_act &  vact_q;

   // Fire only on the transition into saturation so a dead input gives one err.
   assign timeout = ((lc_q == CNT_PRE) && !h_lead) ||
                    ((vc_q == CNT_PRE) && h_lead && !v_lead);
   assign h_upd   = h_lead && hseen_q;
   assign measure = v_lead && ((state_q != ST_SEARCH) || arm_q) && !timeout;

   always_comb begin
      lc_d     = h_lead ? 11'd0 : ((lc_q == CNT_MAX) ? lc_q : lc_q + 11'd1);
      vc_d     = vc_q;
      vp_d     = vp_q;
      htotal_d = h_upd   ? lc_q + 11'd1 : htotal_q;
      hpulse_d = h_trail ? lc_q + 11'd1 : hpulse_q;
      vtotal_d = measure ? vc_q + {10'd0, h_lead} : vtotal_q;
      vpulse_d = v_trail ? vp_q : vpulse_q;
      hseen_d  = timeout ? 1'b0 : (hseen_q | h_lead);
      fd_d     = measure;

      if (v_lead)
         vc_d = 11'd0;
      else if (h_lead && (vc_q != CNT_MAX))
         vc_d = vc_q + 11'd1;

      if (v_lead)
         vp_d = {10'd0, h_lead};
      else if (h_lead && v_act && (vp_q != CNT_MAX))
         vp_d = vp_q + 11'd1;

      state_d  = state_q;
      arm_d    = arm_q;
      cand_h_d = cand_h_q;
      cand_v_d = cand_v_q;
      err_d    = 1'b0;

      if (timeout) begin
         state_d = ST_SEARCH;
         arm_d   = 1'b0;
         err_d   = 1'b1;
      end else begin
         case (state_q)
            ST_SEARCH: begin
               if (v_lead && !arm_q) begin
                  arm_d = 1'b1;
               end else if (measure) begin
                  arm_d    = 1'b0;
                  state_d  = ST_MEASURE;
                  cand_h_d = htotal_d;
                  cand_v_d = vtotal_d;
               end
            end
            ST_MEASURE: begin
               if (measure) begin
                  if ((htotal_d == cand_h_q) && (vtotal_d == cand_v_q)) begin
                     state_d = ST_LOCKED;
                  end else begin
                     cand_h_d = htotal_d;
                     cand_v_d = vtotal_d;
                  end
               end
            end
            ST_LOCKED: begin
               if ((h_upd && (htotal_d != cand_h_q)) ||
                   (measure && (vtotal_d != cand_v_q))) begin
                  err_d    = 1'b1;
                  state_d  = ST_MEASURE;
                  cand_h_d = htotal_d;
                  cand_v_d = vtotal_d;
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         hsync_q  <= 2'd0;
         vsync_q  <= 2'd0;
         hact_q   <= 1'b0;
         vact_q   <= 1'b0;
         lc_q     <= 11'd0;
         vc_q     <= 11'd0;
         vp_q     <= 11'd0;
         htotal_q <= 11'd0;
         hpulse_q <= 11'd0;
         vtotal_q <= 11'd0;
         vpulse_q <= 11'd0;
         cand_h_q <= 11'd0;
         cand_v_q <= 11'd0;
         state_q  <= ST_SEARCH;
         hseen_q  <= 1'b0;
         arm_q    <= 1'b0;
         fd_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         hsync_q  <= {hsync_q[0], hsync};
         vsync_q  <= {vsync_q[0], vsync};
         hact_q   <= h_act;
         vact_q   <= v_act;
         lc_q     <= lc_d;
         vc_q     <= vc_d;
         vp_q     <= vp_d;
         htotal_q <= htotal_d;
         hpulse_q <= hpulse_d;
         vtotal_q <= vtotal_d;
         vpulse_q <= vpulse_d;
         cand_h_q <= cand_h_d;
         cand_v_q <= cand_v_d;
         state_q  <= state_d;
         hseen_q  <= hseen_d;
         arm_q    <= arm_d;
         fd_q     <= fd_d;
         err_q    <= err_d;
      end
   end

   assign htotal     = htotal_q;
   assign hpulse     = hpulse_q;
   assign vtotal     = vtotal_q;
   assign vpulse     = vpulse_q;
   assign hcnt_rx    = lc_q;
   assign vcnt_rx    = vc_q;
   assign locked     = (state_q == ST_LOCKED);
   assign frame_done = fd_q;
   assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: drives synthetic video timing into two monitors (hsync
// active-high and active-low) and checks the measured timing and lock behaviour.
`default_nettype none

module tb_vga_sync_monitor;

   logic clk = 1'b0;
   logic RSTn = 1'b0;
   logic hsync = 1'b0, vsync = 1'b0, hsync_n = 1'b1;

   logic [10:0] htotal, hpulse, vtotal, vpulse, hcnt_rx, vcnt_rx;
   logic        locked, frame_done, err;
   logic [10:0] htotal_n, hpulse_n, vtotal_n, vpulse_n, hcnt_rx_n, vcnt_rx_n;
   logic        locked_n, frame_done_n, err_n;

   int checks = 0, passed = 0;
   int fd_cnt = 0, err_cnt = 0;

   // Timing generator state: line/frame geometry, position and control knobs.
   int g_ht = 64, g_hp = 8, g_vt = 12, g_vp = 2;
   int g_hc = 0, g_vc = 0, g_extra = 0, g_pause = 1;
   int vrises = 0;
   logic prev_v = 1'b0;

   always #5 clk = ~clk;

   vga_sync_monitor #(.HPOL(1'b1), .VPOL(1'b1)) dut (
      .clk(clk), .RSTn(RSTn), .hsync(hsync), .vsync(vsync),
      .htotal(htotal), .hpulse(hpulse), .vtotal(vtotal), .vpulse(vpulse),
      .hcnt_rx(hcnt_rx), .vcnt_rx(vcnt_rx), .locked(locked),
      .frame_done(frame_done), .err(err));

   vga_sync_monitor #(.HPOL(1'b0), .VPOL(1'b1)) dut_n (
      .clk(clk), .RSTn(RSTn), .hsync(hsync_n), .vsync(vsync),
      .htotal(htotal_n), .hpulse(hpulse_n), .vtotal(vtotal_n), .vpulse(vpulse_n),
      .hcnt_rx(hcnt_rx_n), .vcnt_rx(vcnt_rx_n), .locked(locked_n),
      .frame_done(frame_done_n), .err(err_n));

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   task automatic tick();
      @(negedge clk);
      if (g_pause != 0) begin
         hsync = 1'b0;
         vsync = 1'b0;
      end else begin
         hsync = (g_hc < g_hp);
         vsync = (g_vc < g_vp);
         g_hc++;
         if (g_hc >= g_ht + g_extra) begin
            g_hc = 0;
            g_extra = 0;
            g_vc++;
            if (g_vc >= g_vt) g_vc = 0;
         end
      end
      hsync_n = ~hsync;
      if (vsync && !prev_v) vrises++;
      prev_v = vsync;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Advance to the next vsync rise at the pins, then let the sync pipeline settle.
   task automatic wait_vrise();
      int start = vrises;
      int guard = 0;
      while (vrises == start && guard < 60000) begin
         tick();
         guard++;
      end
      if (vrises == start) begin
         checks++;
         $display("FAIL vrise_timeout: no vsync rise within %0d clocks", guard);
      end
      run(6);
   endtask

   task automatic restart(input int ht, input int hp, input int vt, input int vp,
                          input int hc0, input int vc0);
      g_pause = 1;
      RSTn = 1'b0;
      run(3);
      RSTn = 1'b1;
      g_ht = ht; g_hp = hp; g_vt = vt; g_vp = vp;
      g_hc = hc0; g_vc = vc0; g_extra = 0;
      prev_v = 1'b0;
      g_pause = 0;
   endtask

   task automatic test_reset();
      run(4);
      checks++;
      if ({htotal, hpulse, vtotal, vpulse, hcnt_rx, vcnt_rx, locked, frame_done, err} !== 69'd0)
         $display("FAIL reset_outputs: got %h required 0",
                  {htotal, hpulse, vtotal, vpulse, hcnt_rx, vcnt_rx, locked, frame_done, err});
      else passed++;
      checks++;
      if ({htotal_n, vtotal_n, locked_n} !== 23'd0)
         $display("FAIL reset_outputs_n: got %h required 0", {htotal_n, vtotal_n, locked_n});
      else passed++;
   endtask

   // 800x600 line geometry with a short frame; also checks the inverted-hsync instance.
   task automatic test_svga_lines();
      restart(1040, 120, 6, 2, 0, 0);
      wait_vrise();
      wait_vrise();
      checks++;
      if (locked !== 1'b0) $display("FAIL svga_locked_early: got %b required 0", locked);
      else passed++;
      wait_vrise();
      checks++;
      if (locked !== 1'b1) $display("FAIL svga_locked: got %b required 1", locked);
      else passed++;
      checks++;
      if (htotal !== 11'd1040) $display("FAIL svga_htotal: got %0d required 1040", htotal);
      else passed++;
      checks++;
      if (hpulse !== 11'd120) $display("FAIL svga_hpulse: got %0d required 120", hpulse);
      else passed++;
      checks++;
      if (vtotal !== 11'd6) $display("FAIL svga_vtotal: got %0d required 6", vtotal);
      else passed++;
      checks++;
      if (vpulse !== 11'd2) $display("FAIL svga_vpulse: got %0d required 2", vpulse);
      else passed++;
      checks++;
      if ({htotal_n, hpulse_n, locked_n} !== {11'd1040, 11'd120, 1'b1})
         $display("FAIL hpol0_values: got %0d/%0d/%b required 1040/120/1",
                  htotal_n, hpulse_n, locked_n);
      else passed++;
   endtask

   // 666-line frame whose vsync rises on the same clock as hsync at the pins.
   task automatic test_tall_frame();
      restart(16, 2, 666, 6, 0, 0);
      wait_vrise();
      run(16 * 665);
      checks++;
      if (vcnt_rx !== 11'd665) $display("FAIL tall_vcnt_last: got %0d required 665", vcnt_rx);
      else passed++;
      wait_vrise();
      checks++;
      if (vtotal !== 11'd666) $display("FAIL tall_vtotal: got %0d required 666", vtotal);
      else passed++;
      checks++;
      if (vcnt_rx !== 11'd0) $display("FAIL tall_vcnt_zero: got %0d required 0", vcnt_rx);
      else passed++;
      checks++;
      if (vpulse !== 11'd6) $display("FAIL tall_vpulse: got %0d required 6", vpulse);
      else passed++;
      checks++;
      if (vtotal_n !== 11'd666) $display("FAIL tall_vtotal_n: got %0d required 666", vtotal_n);
      else passed++;
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         int ht = $urandom_range(90, 30);
         int hp = $urandom_range(ht / 2, 2);
         int vt = $urandom_range(24, 8);
         int vp = $urandom_range(vt / 3, 1);
         restart(ht, hp, vt, vp, $urandom_range(ht - 1, hp), $urandom_range(vt - 1, vp));
         wait_vrise();
         wait_vrise();
         checks++;
         if (locked !== 1'b0) $display("FAIL rnd%0d_locked_early: got %b required 0", r, locked);
         else passed++;
         wait_vrise();
         checks++;
         if ({htotal, hpulse} !== {ht[10:0], hp[10:0]})
            $display("FAIL rnd%0d_h: got %0d/%0d required %0d/%0d", r, htotal, hpulse, ht, hp);
         else passed++;
         checks++;
         if ({vtotal, vpulse} !== {vt[10:0], vp[10:0]})
            $display("FAIL rnd%0d_v: got %0d/%0d required %0d/%0d", r, vtotal, vpulse, vt, vp);
         else passed++;
         checks++;
         if ({locked, locked_n} !== 2'b11)
            $display("FAIL rnd%0d_locked: got %b%b required 11", r, locked, locked_n);
         else passed++;
      end
   endtask

   task automatic test_stretch();
      int e0;
      restart(64, 8, 12, 2, 0, 0);
      wait_vrise();
      wait_vrise();
      wait_vrise();
      checks++;
      if (locked !== 1'b1) $display("FAIL stretch_prelock: got %b required 1", locked);
      else passed++;
      e0 = err_cnt;
      g_extra = 1;
      run(3 * 64);
      checks++;
      if (err_cnt - e0 !== 1) $display("FAIL stretch_err: got %0d pulses required 1", err_cnt - e0);
      else passed++;
      checks++;
      if (locked !== 1'b0) $display("FAIL stretch_unlock: got %b required 0", locked);
      else passed++;
      wait_vrise();
      checks++;
      if (locked !== 1'b0) $display("FAIL stretch_frame1: got %b required 0", locked);
      else passed++;
      wait_vrise();
      checks++;
      if (locked !== 1'b1) $display("FAIL stretch_relock: got %b required 1", locked);
      else passed++;
      checks++;
      if (err_cnt - e0 !== 1) $display("FAIL stretch_err_total: got %0d required 1", err_cnt - e0);
      else passed++;
   endtask

   task automatic test_timeout();
      int e0 = err_cnt;
      run(3 * 64);
      g_pause = 1;
      run(2100);
      checks++;
      if (err_cnt - e0 !== 1) $display("FAIL timeout_err: got %0d pulses required 1", err_cnt - e0);
      else passed++;
      checks++;
      if (locked !== 1'b0) $display("FAIL timeout_unlock: got %b required 0", locked);
      else passed++;
      g_hc = 0; g_vc = 0; prev_v = 1'b0;
      g_pause = 0;
      wait_vrise();
      wait_vrise();
      checks++;
      if (locked !== 1'b0) $display("FAIL timeout_locked_early: got %b required 0", locked);
      else passed++;
      wait_vrise();
      checks++;
      if (locked !== 1'b1) $display("FAIL timeout_relock: got %b required 1", locked);
      else passed++;
      checks++;
      if (err_cnt - e0 !== 1) $display("FAIL timeout_err_total: got %0d required 1", err_cnt - e0);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      int f0;
      run(6 * 64 + 17);
      RSTn = 1'b0;
      tick();
      checks++;
      if ({htotal, hpulse, vtotal, vpulse, hcnt_rx, vcnt_rx, locked, frame_done, err} !== 69'd0)
         $display("FAIL midreset_outputs: got %h required 0",
                  {htotal, hpulse, vtotal, vpulse, hcnt_rx, vcnt_rx, locked, frame_done, err});
      else passed++;
      tick();
      RSTn = 1'b1;
      f0 = fd_cnt;
      wait_vrise();
      checks++;
      if (fd_cnt - f0 !== 0) $display("FAIL midreset_fd1: got %0d pulses required 0", fd_cnt - f0);
      else passed++;
      checks++;
      if (vtotal !== 11'd0) $display("FAIL midreset_vtotal1: got %0d required 0", vtotal);
      else passed++;
      wait_vrise();
      checks++;
      if (fd_cnt - f0 !== 1) $display("FAIL midreset_fd2: got %0d pulses required 1", fd_cnt - f0);
      else passed++;
      checks++;
      if ({vtotal, locked} !== {11'd12, 1'b0})
         $display("FAIL midreset_vtotal2: got %0d/%b required 12/0", vtotal, locked);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_svga_lines();
      test_tall_frame();
      test_random();
      test_stretch();
      test_timeout();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire
